spi_bridge: RTL

SPI-slave front end that sits directly upstream of the peripheral register file. It converts 16-bit SPI mode-0 frames into single-cycle read/write strobes with addr, data_write and data_read. Runs entirely in the clk domain and oversamples sclk, cs_n and mosi. clk must be at least 4x sclk.

---
 rtl/spi_bridge_pkg.sv | 17 +
 rtl/spi_bridge_if.sv | 27 ++
 rtl/spi_bridge_sync_edge.sv | 33 +++
 rtl/spi_bridge.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared constants and FSM encoding for the SPI-to-register-file bridge.
package spi_bridge_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 7;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        WAIT_CS
    } state_e;

endpackage

// File: rtl/spi_bridge_if.sv
// SPI pins plus the register-file strobe bus seen by the bridge.
interface spi_bridge_if;
    import spi_bridge_pkg::*;

    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    // The bridge itself.
    modport slave (
        input  sclk, cs_n, mosi, data_read,
        output miso, read, write, addr, data_write
    );

    // SPI master and register file seen from the outside.
    modport master (
        output sclk, cs_n, mosi, data_read,
        input  miso, read, write, addr, data_write
    );

endinterface

// File: rtl/spi_bridge_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the
// synchronized value. Resets to 0 so a level already low at reset release
// never looks like a falling edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the async input through the synchronizer and remember the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o =  q_o & ~prev_q;
    assign fall_o = ~q_o &  prev_q;

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 slave that turns 16-bit frames {rw,rsvd,addr[5:0]},{data}
// into single-cycle read/write strobes for the register file. Everything
// runs in clk; sclk/cs_n/mosi are oversampled.
module spi_bridge
    import spi_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_bridge_if.slave  bus
);

    logic sclk_rise, sclk_fall, sclk_s;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s;
    logic rise_en, fall_en;

    logic [SYNC_STAGES-1:0] mosi_sync_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cmd_sr_q, cmd_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dw_q, dw_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              miso_q, miso_d;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.sclk),
        .q_o    (sclk_s),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (bus.cs_n),
        .q_o    (cs_s),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    // mosi gets the same depth as sclk so it lines up with the detected edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    end

    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    // sclk activity only counts while the chip is selected.
    assign rise_en = sclk_rise & ~cs_s;
    assign fall_en = sclk_fall & ~cs_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: start on cs_n fall, abort on cs_n high, advance on bit counts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = CMD;
            CMD:     if (cs_s) state_d = IDLE;
                     else if (rise_en && cnt_q == CNT_W'(DATA_W - 1)) state_d = DATA;
            DATA:    if (cs_s || cs_rise) state_d = IDLE;
                     else if (rise_en && cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = WAIT_CS;
            WAIT_CS: if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: shifting, address/strobe generation and miso.
    always_comb begin
        cnt_d    = cnt_q;
        cmd_sr_d = cmd_sr_q;
        rx_sr_d  = rx_sr_q;
        tx_sr_d  = tx_sr_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        dw_d     = dw_q;
        read_d   = 1'b0;
        write_d  = 1'b0;
        miso_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) cnt_d = '0;
            end
            CMD: begin
                if (rise_en) begin
                    cmd_sr_d = {cmd_sr_q[DATA_W-2:0], mosi_s};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        addr_d = cmd_sr_d[ADDR_W-1:0];
                        rw_d   = cmd_sr_d[RW_BIT];
                        read_d = ~cmd_sr_d[RW_BIT];
                    end
                end
            end
            DATA: begin
                if (!cs_s) begin
                    // Read data is captured in the strobe cycle itself.
                    if (read_q) tx_sr_d = bus.data_read;
                    if (!rw_q) begin
                        miso_d = miso_q;
                        if (fall_en) begin
                            miso_d  = tx_sr_q[DATA_W-1];
                            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    if (rise_en) begin
                        cnt_d = cnt_q + 1'b1;
                        if (rw_q) begin
                            rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_s};
                            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                                dw_d    = rx_sr_d;
                                write_d = 1'b1;
                            end
                        end
                    end
                end
            end
            WAIT_CS: ;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            cmd_sr_q <= '0;
            rx_sr_q  <= '0;
            tx_sr_q  <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            dw_q     <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cmd_sr_q <= cmd_sr_d;
            rx_sr_q  <= rx_sr_d;
            tx_sr_q  <= tx_sr_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            dw_q     <= dw_d;
            read_q   <= read_d;
            write_q  <= write_d;
            miso_q   <= miso_d;
        end
    end

    assign bus.read       = read_q;
    assign bus.write      = write_q;
    assign bus.addr       = addr_q;
    assign bus.data_write = dw_q;
    assign bus.miso       = miso_q;

endmodule
